mem_burst_ctrl: RTL and testbench
=================================

# mem_burst_ctrl

Burst access controller sitting directly upstream of the 32 x 32-bit single-port data memory. It accepts one burst command at a time (start address, length, direction) over a valid/ready handshake. It then streams write beats from an upstream producer into the memory, or streams read beats from the memory to a downstream consumer. It drives the memory's write-enable, read-enable, address and write-data ports and absorbs the memory's fixed 1-cycle registered read latency with a 4-entry read buffer, so backpressure on the read stream never loses data.

## Interface
- AW, 5, memory address width (32 locations)
- DW, 32, data width
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  burst command present
- cmd_ready  out  1  controller idle, command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  start address
- cmd_len  in  5  beats minus one (0 -> 1 beat, 31 -> 32 beats)
- wr_valid / wr_ready  in / out  1  write-beat handshake
- wr_data  in  DW  write beat
- rd_valid / rd_ready  out / in  1  read-beat handshake
- rd_data  out  DW  read beat (buffer head)
- busy  out  1  state != IDLE
- mem_wd_en  out  1  memory write enable
- mem_rd_en  out  1  memory read enable
- mem_addr  out  AW  memory address
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data, valid the cycle after the address is presented

## Operation
- Reset values: state IDLE, address/beat counters 0, read buffer empty, pending-read flag 0. While rst is high, cmd_ready, wr_ready, rd_valid, busy, mem_wd_en and mem_rd_en are 0, and mem_addr and mem_din are 0.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On accept, latch addr and remaining = cmd_len. Go to WRITE if cmd_write, else READ.
- WRITE: wr_ready=1. Each beat (wr_valid & wr_ready) drives mem_wd_en=1, mem_addr=addr and mem_din=wr_data combinationally in the same cycle. On that beat, addr increments and remaining decrements. After the beat with remaining==0, go to IDLE.
- READ: issue (mem_rd_en=1, mem_addr=addr) only when count + pending <= 2. count is buffer occupancy at start of cycle; pending=1 if a read was issued last cycle. On issue, addr increments and remaining decrements. After the issue with remaining==0, go to DRAIN.
- The data of an issue in cycle N is read from mem_dout in N+1 and pushed into the buffer at the end of N+1.
- DRAIN: no issues. Go to IDLE when pending==0 and count==0 (last beat popped).
- Read buffer: 4-entry FIFO. rd_valid = count != 0. Pop on rd_valid & rd_ready. Simultaneous push and pop in one cycle leaves count unchanged. The issue rule guarantees the buffer never overflows.
- Address arithmetic is mod 2^AW: 31 + 1 wraps to 0. A burst may span the wrap.
- mem_wd_en and mem_rd_en are never both 1. Outside WRITE both are 0 and mem_din=0.
- Reset asserted mid-burst aborts immediately. Buffered and in-flight read data is discarded and memory writes stop in the same cycle.

## Timing
- Command accept at edge 0. The first write beat can be accepted in cycle 1, giving 1 beat/cycle while wr_valid is held.
- Read: the first issue is in cycle 1, the first rd_valid is in cycle 3, and sustained 1 beat/cycle follows with rd_ready held high.
- A new command is accepted earliest the cycle after WRITE exits, or the cycle after DRAIN empties.
- rd_data is stable while rd_valid & !rd_ready (AXI-style hold). Likewise wr_data must be held by the producer until accepted.

## Test plan
- Write addr 3, len 3, data 0xA0..0xA3, wr_valid always 1 -> mem_wd_en high for 4 consecutive cycles at addr 3,4,5,6; busy drops after the 4th beat.
- Then read addr 3, len 3, rd_ready=1 -> rd_valid from cycle 3 for 4 cycles, rd_data 0xA0,0xA1,0xA2,0xA3 in order, then IDLE.
- Write addr 30, len 3 (0x1E1E..), then read it back -> writes land at 30,31,0,1; the read returns the same order.
- Read 8 beats with rd_ready low for 10 cycles after the first rd_valid -> exactly 3 issues then stall (count + pending cap). No data lost; all 8 beats arrive in order once rd_ready=1.
- Write burst with wr_valid toggling 1,0,1,0 -> mem_wd_en only on valid cycles; the address advances only on accepted beats.
- Assert rst for 1 cycle during beat 2 of an 8-beat read -> rd_valid=0 and cmd_ready=1 after release; the next command executes normally from its own start address.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: one-command-at-a-time burst controller in front of a
// 32 x 32-bit single-port memory. Write bursts stream straight through to
// the memory. Read bursts are issued ahead of the consumer and land in a
// small FIFO that absorbs the memory's 1-cycle read latency.
module mem_burst_ctrl #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          rst,
    // command channel
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    // write-beat stream
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    // read-beat stream
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    // status
    output logic          busy,
    // memory side
    output logic          mem_wd_en,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          pend_q, pend_d;

    // read buffer: 4 entries, pointer pair plus explicit occupancy
    logic [DW-1:0] buf_q [4];
    logic [1:0]    wptr_q, wptr_d;
    logic [1:0]    rptr_q, rptr_d;
    logic [2:0]    cnt_q, cnt_d;

    logic          issue;
    logic          room;
    logic          push;
    logic          pop;

    // Data requested last cycle is on mem_dout now; it enters the buffer at
    // the end of this cycle. A pop needs a non-empty buffer at cycle start.
    assign push     = pend_q;
    assign pop      = (cnt_q != 3'd0) && rd_ready && !rst;
    // Issue only if everything buffered or in flight, plus this issue, fits
    // in three slots; this keeps the 4-entry buffer from ever overflowing.
    assign room     = (cnt_q + {2'b00, pend_q}) <= 3'd2;

    assign rd_valid = (cnt_q != 3'd0) && !rst;
    assign rd_data  = buf_q[rptr_q];
    assign busy     = (state_q != S_IDLE) && !rst;

    // Buffer occupancy and pointer bookkeeping
    always_comb begin
        cnt_d  = cnt_q + {2'b00, push} - {2'b00, pop};
        wptr_d = push ? wptr_q + 2'd1 : wptr_q;
        rptr_d = pop  ? rptr_q + 2'd1 : rptr_q;
        pend_d = issue;
    end

    // Next-state, counters and memory/handshake outputs
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        issue     = 1'b0;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_wd_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    state_d = cmd_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                wr_ready = 1'b1;
                mem_addr = addr_q;
                mem_din  = wr_data;
                if (wr_valid) begin
                    mem_wd_en = 1'b1;
                    addr_d    = addr_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
                    if (rem_q == '0) state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (room) begin
                    issue     = 1'b1;
                    mem_rd_en = 1'b1;
                    mem_addr  = addr_q;
                    addr_d    = addr_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
                    if (rem_q == '0) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // leave once the final in-flight beat has landed and been popped
                if (!pend_q && (cnt_d == 3'd0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state register; reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= 3'd0;
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Buffer storage; validity is tracked by cnt_q so no reset is needed
    always_ff @(posedge clk) begin
        if (push) buf_q[wptr_q] <= mem_dout;
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: table of directed bursts, a reset-abort
// sequence and randomized bursts, all checked against a shadow memory.
module tb_mem_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr, cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        busy, mem_wd_en, mem_rd_en;
    logic [4:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem     [32];
    logic [31:0] ref_mem [32];

    always #5 clk = ~clk;

    mem_burst_ctrl #(.AW(5), .DW(32), .LW(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .mem_wd_en(mem_wd_en), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // single-port memory with registered read
    initial for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
    always @(posedge clk) begin
        if (mem_wd_en) mem[mem_addr] <= mem_din;
        if (mem_rd_en) mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] wrap(input int x);
        return x[4:0];
    endfunction

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [4:0]  len;
        logic [31:0] base;
        int          wv;        // 0 always valid, 1 toggle, 2 random
        int          rr;        // 0 always ready, 1 stall 10 after first valid, 2 random
        int          exp_busy;  // expected busy cycles, -1 = not checked
    } vec_t;

    // Runs one burst. Entered and left 1 time unit after a rising edge.
    task automatic run_cmd(input vec_t v, input string nm);
        int beats = 0, issues = 0, pops = 0, cyc = 0, first_v = 0;
        int stall_left = 10, t = 0, busy_cyc = 0;
        bit done = 0;
        logic [31:0] q[$];
        logic [31:0] e;
        while (!cmd_ready && t < 50) begin @(posedge clk); #1; t++; end
        chk({nm, "/cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
        wr_valid = 1'b0; rd_ready = 1'b0;
        if (!v.wr)
            for (int k = 0; k <= int'(v.len); k++) q.push_back(ref_mem[wrap(int'(v.addr) + k)]);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            wr_data  = v.base + 32'(beats);
            wr_valid = v.wr && ((v.wv == 0) ? 1'b1 : (v.wv == 1) ? cyc[0] : 1'($urandom_range(1)));
            case (v.rr)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (first_v != 0) && (stall_left == 0);
                default: rd_ready = 1'($urandom_range(1));
            endcase
            @(negedge clk);
            if (!busy) begin
                done = 1;
                busy_cyc = cyc - 1;
            end else if (v.wr) begin
                chk({nm, "/wd_en"}, 32'(mem_wd_en), 32'(wr_valid));
                if (mem_wd_en) begin
                    chk({nm, "/wr_addr"}, 32'(mem_addr), 32'(wrap(int'(v.addr) + beats)));
                    chk({nm, "/wr_din"}, mem_din, v.base + 32'(beats));
                    ref_mem[wrap(int'(v.addr) + beats)] = v.base + 32'(beats);
                    beats++;
                end
            end else begin
                chk({nm, "/no_wd"}, {31'd0, mem_wd_en}, 32'd0);
                if (mem_rd_en) begin
                    chk({nm, "/rd_addr"}, 32'(mem_addr), 32'(wrap(int'(v.addr) + issues)));
                    issues++;
                    chk({nm, "/outstanding<=3"}, 32'((issues - pops) <= 3), 32'd1);
                end
                if (rd_valid && first_v == 0) first_v = cyc;
                else if (v.rr == 1 && first_v != 0 && stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) chk({nm, "/stall_issues"}, 32'(issues), 32'd3);
                end
                if (rd_valid && rd_ready) begin
                    e = (q.size() != 0) ? q.pop_front() : 32'hBAD0_BAD0;
                    chk({nm, "/rd_data"}, rd_data, e);
                    pops++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
        chk({nm, "/terminated"}, 32'(done), 32'd1);
        chk({nm, "/beats"}, 32'(v.wr ? beats : pops), 32'(int'(v.len) + 1));
        if (v.exp_busy >= 0) chk({nm, "/busy_cycles"}, 32'(busy_cyc), 32'(v.exp_busy));
        if (!v.wr && v.rr == 0) chk({nm, "/first_rd_valid"}, 32'(first_v), 32'd3);
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'hDEAD_0000 + 32'(i);
        tbl[0]  = '{1'b1, 5'd3,  5'd3,  32'h0000_00A0, 0, 0, 4};
        tbl[1]  = '{1'b0, 5'd3,  5'd3,  32'h0,         0, 0, 6};
        tbl[2]  = '{1'b1, 5'd30, 5'd3,  32'h1E1E_1E00, 0, 0, 4};
        tbl[3]  = '{1'b0, 5'd30, 5'd3,  32'h0,         0, 0, 6};
        tbl[4]  = '{1'b1, 5'd10, 5'd7,  32'h5000_0000, 0, 0, 8};
        tbl[5]  = '{1'b0, 5'd10, 5'd7,  32'h0,         0, 1, -1};
        tbl[6]  = '{1'b1, 5'd20, 5'd3,  32'h7700_0000, 1, 0, 7};
        tbl[7]  = '{1'b0, 5'd20, 5'd3,  32'h0,         0, 0, 6};
        tbl[8]  = '{1'b0, 5'd0,  5'd0,  32'h0,         0, 0, 3};
        tbl[9]  = '{1'b1, 5'd31, 5'd31, 32'hC000_0000, 0, 0, 32};
        tbl[10] = '{1'b0, 5'd31, 5'd31, 32'h0,         0, 0, 34};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst/cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst/busy",      32'(busy),      32'd0);
        chk("rst/rd_valid",  32'(rd_valid),  32'd0);
        chk("rst/wr_ready",  32'(wr_ready),  32'd0);
        chk("rst/mem_en",    32'({mem_wd_en, mem_rd_en}), 32'd0);
        chk("rst/mem_addr",  32'(mem_addr),  32'd0);
        chk("rst/mem_din",   mem_din,        32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst/cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // reset during the second beat of an 8-beat read
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd5; cmd_len = 5'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0; rd_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("abort/rd_valid",  32'(rd_valid),  32'd0);
        chk("abort/busy",      32'(busy),      32'd0);
        chk("abort/mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("abort/cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        chk("abort_rel/rd_valid",  32'(rd_valid),  32'd0);
        chk("abort_rel/cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_rel/busy",      32'(busy),      32'd0);
        @(posedge clk); #1;
        rv = '{1'b0, 5'd9, 5'd2, 32'h0, 0, 0, 5};
        run_cmd(rv, "after_abort");

        for (int i = 0; i < 20; i++) begin
            rv.wr       = 1'($urandom_range(1));
            rv.addr     = 5'($urandom_range(31));
            rv.len      = 5'($urandom_range(31));
            rv.base     = $urandom;
            rv.wv       = 2;
            rv.rr       = 2;
            rv.exp_busy = -1;
            run_cmd(rv, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
